// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC             = 32'd4;
  localparam logic [31:0] DEFAULT_BOOT_PC    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hffff_fffc;
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority selection of the redirect source: exception, then EX branch, then ID jump.
module pc_redirect_sel
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        exc_req,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  always_comb begin
    redir_valid  = exc_req | br_taken | jmp_req;
    redir_target = 32'd0;
    if (exc_req) begin
      redir_target = word_align(EXC_VECTOR);
    end else if (br_taken) begin
      redir_target = word_align(br_target);
    end else if (jmp_req) begin
      redir_target = word_align(jmp_target);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: drives PC register updates and instruction-memory requests,
// merging redirects and stalls into one ordered PC stream.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
  parameter logic [31:0] BOOT_PC    = DEFAULT_BOOT_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  input  logic        imem_ready,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        if_valid,
  output logic        flush
);

  fetch_state_t state, state_next;
  logic [31:0]  redir_q, redir_next;
  logic         redir_valid;
  logic [31:0]  redir_target;

  pc_redirect_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_redirect_sel (
    .exc_req     (exc_req),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_req     (jmp_req),
    .jmp_target  (jmp_target),
    .redir_valid (redir_valid),
    .redir_target(redir_target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BOOT;
      redir_q <= 32'd0;
    end else begin
      state   <= state_next;
      redir_q <= redir_next;
    end
  end

  assign imem_addr = pc_cur;

  // Outputs are forced low while reset is held so nothing leaks from the BOOT decode.
  always_comb begin
    state_next = state;
    redir_next = redir_q;
    pc_next    = 32'd0;
    pc_write   = 1'b0;
    imem_req   = 1'b0;
    if_valid   = 1'b0;
    flush      = 1'b0;
    if (rst) begin
      unique case (state)
        BOOT: begin
          pc_write   = 1'b1;
          pc_next    = BOOT_PC;
          state_next = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          if (redir_valid) begin
            flush = 1'b1;
            if (imem_ready) begin
              pc_write = 1'b1;
              pc_next  = redir_target;
            end else begin
              redir_next = redir_target;
              state_next = DRAIN;
            end
          end else if (imem_ready && !stall) begin
            if_valid = 1'b1;
            pc_write = 1'b1;
            pc_next  = pc_cur + PC_INC;
          end
        end
        DRAIN: begin
          // The outstanding response belongs to the abandoned path and is always dropped.
          imem_req = 1'b1;
          if (redir_valid) begin
            flush      = 1'b1;
            redir_next = redir_target;
          end
          if (imem_ready) begin
            pc_write   = 1'b1;
            pc_next    = redir_valid ? redir_target : redir_q;
            state_next = FETCH;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by randomized traffic,
// checked against a behavioural model of the fetch sequencing rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_0180;
  localparam logic [31:0] BOOT_AT = 32'h0000_0000;

  localparam int M_BOOT  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DRAIN = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall;
  logic        exc_req;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_req;
  logic [31:0] jmp_target;
  logic        imem_ready;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic        flush;

  int          checks = 0;
  int          passes = 0;
  int          mdl_mode = M_BOOT;
  logic [31:0] mdl_pending = 32'd0;
  int          fetched_count = 0;

  pc_fetch_ctrl #(
    .EXC_VECTOR(EXC_VEC),
    .BOOT_PC   (BOOT_AT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_cur    (pc_cur),
    .stall     (stall),
    .exc_req   (exc_req),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp_req   (jmp_req),
    .jmp_target(jmp_target),
    .imem_ready(imem_ready),
    .pc_next   (pc_next),
    .pc_write  (pc_write),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .if_valid  (if_valid),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: apply inputs just after the edge, compare mid-cycle, then let the
  // bench-side PC register follow the expected write at the next edge.
  task automatic do_cycle(input logic r, input logic s, input logic e, input logic b,
                          input logic j, input logic rdy,
                          input logic [31:0] bt, input logic [31:0] jt);
    logic        any_redir;
    logic [31:0] dest;
    logic        e_pw, e_req, e_val, e_fl;
    logic [31:0] e_pn;
    int          n_mode;
    logic [31:0] n_pend;

    rst = r; stall = s; exc_req = e; br_taken = b; jmp_req = j;
    imem_ready = rdy; br_target = bt; jmp_target = jt;
    #3;

    any_redir = e | b | j;
    if (e)      dest = EXC_VEC;
    else if (b) dest = bt;
    else        dest = jt;
    dest = {dest[31:2], 2'b00};

    e_pw = 1'b0; e_req = 1'b0; e_val = 1'b0; e_fl = 1'b0; e_pn = 32'd0;
    n_mode = mdl_mode; n_pend = mdl_pending;
    if (!r) begin
      n_mode = M_BOOT;
      n_pend = 32'd0;
    end else if (mdl_mode == M_BOOT) begin
      e_pw = 1'b1; e_pn = BOOT_AT; n_mode = M_FETCH;
    end else if (mdl_mode == M_FETCH) begin
      e_req = 1'b1;
      e_fl  = any_redir;
      if (any_redir && rdy) begin
        e_pw = 1'b1; e_pn = dest;
      end else if (any_redir) begin
        n_pend = dest; n_mode = M_DRAIN;
      end else if (rdy && !s) begin
        e_val = 1'b1; e_pw = 1'b1; e_pn = pc_cur + 32'd4;
      end
    end else begin
      e_req = 1'b1;
      e_fl  = any_redir;
      if (any_redir) n_pend = dest;
      if (rdy) begin
        e_pw = 1'b1; e_pn = n_pend; n_mode = M_FETCH;
      end
    end

    $display("t=%0t rst=%b stall=%b exc=%b br=%b jmp=%b rdy=%b pc=%h -> pc_write=%b pc_next=%h req=%b valid=%b flush=%b",
             $time, r, s, e, b, j, rdy, pc_cur, pc_write, pc_next, imem_req, if_valid, flush);
    chk("pc_write", {31'd0, pc_write}, {31'd0, e_pw});
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    chk("if_valid", {31'd0, if_valid}, {31'd0, e_val});
    chk("flush", {31'd0, flush}, {31'd0, e_fl});
    if (e_pw) chk("pc_next", pc_next, e_pn);
    if (r) chk("imem_addr", imem_addr, pc_cur);
    if (e_val) fetched_count++;

    @(posedge clk);
    #1;
    if (e_pw) pc_cur = e_pn;
    mdl_mode    = n_mode;
    mdl_pending = n_pend;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; exc_req = 1'b0; br_taken = 1'b0; jmp_req = 1'b0;
    imem_ready = 1'b1; br_target = 32'd0; jmp_target = 32'd0; pc_cur = 32'd0;
    #1;

    // Reset held, then boot and four sequential fetches 0,4,8,C.
    do_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", pc_cur, 32'(i * 4));
      do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    end

    // Three stalled cycles at 0x10, then resume.
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", imem_addr, 32'h10);
      do_cycle(1, 1, 0, 0, 0, 1, 0, 0);
    end
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    chk("resume_addr", pc_cur, 32'h14);

    // Branch with ready memory: misaligned target gets aligned.
    do_cycle(1, 0, 0, 1, 0, 1, 32'h41, 0);
    chk("branch_addr", pc_cur, 32'h40);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // Jump while memory is busy: drain two more cycles, late response discarded.
    do_cycle(1, 0, 0, 0, 1, 0, 0, 32'h80);
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    chk("jump_addr", pc_cur, 32'h80);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // All three redirect sources at once: exception wins.
    do_cycle(1, 1, 1, 1, 1, 1, 32'h200, 32'h300);
    chk("exc_addr", pc_cur, EXC_VEC);

    // Branch arriving during a jump drain overrides the jump.
    do_cycle(1, 0, 0, 0, 1, 0, 0, 32'h500);
    do_cycle(1, 0, 0, 1, 0, 0, 32'h604, 0);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    chk("drain_br_addr", pc_cur, 32'h604);

    // Address wrap at the top of memory.
    do_cycle(1, 0, 0, 0, 1, 1, 0, 32'hffff_fffc);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    chk("wrap_addr", pc_cur, 32'h0);

    // Reset asserted mid-drain: outputs drop at once, pending target is lost.
    do_cycle(1, 0, 0, 0, 1, 0, 0, 32'h700);
    do_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    chk("reboot_addr", pc_cur, BOOT_AT);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      do_cycle(1,
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 2) != 0),
               $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
